// File: rtl/valve_driver.sv
// Two-zone irrigation valve driver: one seal-break / settle / PWM-hold FSM per zone,
// with a shared 2-bit phase counter setting the hold duty cycle.
`timescale 1ns/1ps
module valve_driver #(
    parameter int unsigned SETTLE  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] R1,
    input  logic [1:0] R2,
    input  logic [1:0] E,
    input  logic       fb1,
    input  logic       fb2,
    input  logic       clr_fault,
    output logic       V1,
    output logic       V2,
    output logic [1:0] ST1,
    output logic [1:0] ST2,
    output logic       F
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SettleLast  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CntMax      = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing,
        StFault
    } state_e;

    state_e          state_q [2];
    state_e          state_d [2];
    logic [1:0]      level_q [2];
    logic [1:0]      level_d [2];
    logic [CW-1:0]   cnt_q   [2];
    logic [CW-1:0]   cnt_d   [2];
    logic [1:0]      phase_q;

    logic [1:0]      cmd     [2];
    logic            fb      [2];
    logic            err;
    logic            v       [2];
    logic [1:0]      st      [2];
    logic [2:0]      duty    [2];

    always_comb begin
        cmd[0] = R1;
        cmd[1] = R2;
        fb[0]  = fb1;
        fb[1]  = fb2;
    end

    assign err = (E == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StClosed;
                level_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            phase_q <= phase_q + 2'd1;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Fault conditions outrank the error override, which outranks commands.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            case (state_q[i])
                StClosed: begin
                    if (cmd[i] != 2'b00 && !err) begin
                        state_d[i] = StOpening;
                        level_d[i] = cmd[i];
                    end
                end
                StOpening: begin
                    if (fb[i] && cnt_q[i] >= SettleLast) begin
                        state_d[i] = err ? StClosing : StOpen;
                    end else if (cnt_q[i] == TimeoutLast) begin
                        state_d[i] = StFault;
                    end else if (err) begin
                        state_d[i] = StClosing;
                    end
                end
                StOpen: begin
                    if (!fb[i]) begin
                        state_d[i] = StFault;
                    end else if (err || cmd[i] == 2'b00) begin
                        state_d[i] = StClosing;
                    end else begin
                        level_d[i] = cmd[i];
                    end
                end
                StClosing: begin
                    if (!fb[i] && cnt_q[i] >= SettleLast) begin
                        state_d[i] = StClosed;
                    end else if (cnt_q[i] == TimeoutLast) begin
                        state_d[i] = StFault;
                    end
                end
                StFault: begin
                    if (clr_fault && cmd[i] == 2'b00) begin
                        state_d[i] = StClosed;
                    end
                end
                default: state_d[i] = StClosed;
            endcase

            if (state_d[i] != state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            case (level_q[i])
                2'b01:   duty[i] = 3'd1;
                2'b10:   duty[i] = 3'd2;
                2'b11:   duty[i] = 3'd4;
                default: duty[i] = 3'd0;
            endcase
            v[i]  = 1'b0;
            st[i] = 2'b00;
            case (state_q[i])
                StOpening: begin
                    v[i]  = 1'b1;
                    st[i] = 2'b01;
                end
                StOpen: begin
                    v[i]  = ({1'b0, phase_q} < duty[i]);
                    st[i] = 2'b10;
                end
                StClosing: st[i] = 2'b01;
                StFault:   st[i] = 2'b11;
                default:   st[i] = 2'b00;
            endcase
        end
        V1  = v[0];
        V2  = v[1];
        ST1 = st[0];
        ST2 = st[1];
        F   = (st[0] == 2'b11) | (st[1] == 2'b11);
    end

endmodule

// File: tb/tb_valve_driver.sv
// Directed and randomized checks of valve_driver against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_valve_driver;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] R1, R2, E;
    logic       fb1, fb2, clr_fault;
    logic       V1, V2, F;
    logic [1:0] ST1, ST2;

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 closed, 1 opening, 2 open, 3 closing, 4 fault; age = cycles in state.
    int m_st  [2];
    int m_lvl [2];
    int m_age [2];
    int m_phase;

    valve_driver #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .R1        (R1),
        .R2        (R2),
        .E         (E),
        .fb1       (fb1),
        .fb2       (fb2),
        .clr_fault (clr_fault),
        .V1        (V1),
        .V2        (V2),
        .ST1       (ST1),
        .ST2       (ST2),
        .F         (F)
    );

    always #5 clk = ~clk;

    function automatic int st_code(input int s);
        case (s)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int exp_v(input int ch);
        if (m_st[ch] == 1) return 1;
        if (m_st[ch] == 2 && m_lvl[ch] != 0) return (m_phase < (1 << (m_lvl[ch] - 1))) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < 2; i++) begin
            m_st[i]  = 0;
            m_lvl[i] = 0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_update();
        int c [2];
        int b [2];
        int nxt;
        bit er;
        c[0] = int'(R1);
        c[1] = int'(R2);
        b[0] = int'(fb1);
        b[1] = int'(fb2);
        er   = (E == 2'b11);
        for (int i = 0; i < 2; i++) begin
            nxt = m_st[i];
            case (m_st[i])
                0: if (c[i] != 0 && !er) begin nxt = 1; m_lvl[i] = c[i]; end
                1: begin
                    if (b[i] == 1 && m_age[i] >= SETTLE - 1) nxt = er ? 3 : 2;
                    else if (m_age[i] == TIMEOUT - 1) nxt = 4;
                    else if (er) nxt = 3;
                end
                2: begin
                    if (b[i] == 0) nxt = 4;
                    else if (er || c[i] == 0) nxt = 3;
                    else m_lvl[i] = c[i];
                end
                3: begin
                    if (b[i] == 0 && m_age[i] >= SETTLE - 1) nxt = 0;
                    else if (m_age[i] == TIMEOUT - 1) nxt = 4;
                end
                default: if (clr_fault && c[i] == 0) nxt = 0;
            endcase
            m_age[i] = (nxt != m_st[i]) ? 0 : m_age[i] + 1;
            m_st[i]  = nxt;
        end
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("V1", int'(V1), exp_v(0));
        chk("V2", int'(V2), exp_v(1));
        chk("ST1", int'(ST1), st_code(m_st[0]));
        chk("ST2", int'(ST2), st_code(m_st[1]));
        chk("F", int'(F), (m_st[0] == 4 || m_st[1] == 4) ? 1 : 0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (reset) model_reset();
            else model_update();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        int hi;
        int len;
        reset = 1'b1;
        R1 = 2'b00; R2 = 2'b00; E = 2'b00;
        fb1 = 1'b0; fb2 = 1'b0; clr_fault = 1'b0;
        model_reset();
        #2;
        check_outputs();
        chk("reset_ST1", int'(ST1), 0);
        chk("reset_F", int'(F), 0);
        step(2);

        // Zone 1 medium: command applied on the first edge after reset release.
        R1 = 2'b10;
        reset = 1'b0;
        step(1);
        chk("open_start_ST1", int'(ST1), 1);
        chk("open_start_V1", int'(V1), 1);
        step(2);
        fb1 = 1'b1;
        step(5);
        chk("settling_ST1", int'(ST1), 1);
        step(1);
        chk("opened_ST1", int'(ST1), 2);
        hi = 0;
        repeat (4) begin step(1); hi += int'(V1); end
        chk("duty_medium", hi, 2);
        R1 = 2'b00;
        step(1);
        chk("closing_ST1", int'(ST1), 1);
        chk("closing_V1", int'(V1), 0);
        fb1 = 1'b0;
        step(7);
        chk("closing_hold_ST1", int'(ST1), 1);
        step(1);
        chk("closed_ST1", int'(ST1), 0);

        // Zone 2 never reaches its limit switch.
        R2 = 2'b01;
        step(16);
        chk("timeout_pending_ST2", int'(ST2), 1);
        step(1);
        chk("timeout_ST2", int'(ST2), 3);
        chk("timeout_F", int'(F), 1);
        chk("timeout_V2", int'(V2), 0);
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("clr_ignored_ST2", int'(ST2), 3);
        R2 = 2'b00;
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("clr_ok_ST2", int'(ST2), 0);

        // Both full open, then controller error.
        R1 = 2'b11; R2 = 2'b11; fb1 = 1'b1; fb2 = 1'b1;
        step(9);
        chk("full_ST1", int'(ST1), 2);
        chk("full_ST2", int'(ST2), 2);
        E = 2'b11;
        step(1);
        chk("err_ST1", int'(ST1), 1);
        chk("err_ST2", int'(ST2), 1);
        chk("err_V1", int'(V1), 0);
        chk("err_V2", int'(V2), 0);
        R1 = 2'b00; R2 = 2'b00; fb1 = 1'b0; fb2 = 1'b0;
        step(8);
        chk("err_closed_ST1", int'(ST1), 0);
        R1 = 2'b01;
        step(1);
        chk("err_blocks_ST1", int'(ST1), 0);
        E = 2'b00; R1 = 2'b00;
        step(1);

        // Level change while open.
        R1 = 2'b01; fb1 = 1'b1;
        step(9);
        chk("low_ST1", int'(ST1), 2);
        R1 = 2'b11;
        repeat (4) begin step(1); chk("relevel_V1", int'(V1), 1); end
        chk("relevel_ST1", int'(ST1), 2);

        // Dropout and error together: the fault wins.
        fb1 = 1'b0; E = 2'b11;
        step(1);
        chk("drop_ST1", int'(ST1), 3);
        E = 2'b00; R1 = 2'b00; clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("drop_clr_ST1", int'(ST1), 0);

        // Reset in the middle of opening.
        R1 = 2'b10;
        step(6);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("midreset_ST1", int'(ST1), 0);
        chk("midreset_V1", int'(V1), 0);
        step(1);
        reset = 1'b0;
        fb1 = 1'b1;
        step(1);
        chk("restart_ST1", int'(ST1), 1);
        step(7);
        chk("restart_hold_ST1", int'(ST1), 1);
        step(1);
        chk("restart_open_ST1", int'(ST1), 2);

        // Randomized segments.
        repeat (40) begin
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_outputs();
                step(1);
                reset = 1'b0;
            end
            R1  = 2'($urandom_range(0, 3));
            R2  = 2'($urandom_range(0, 3));
            E   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            fb1 = ($urandom_range(0, 3) != 0);
            fb2 = ($urandom_range(0, 3) != 0);
            clr_fault = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 20);
            step(1);
            clr_fault = 1'b0;
            step(len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/valve_driver.md
VALVE_DRIVER -- requirements
Module: valve_driver

Interface
REQ-001 Parameter: SETTLE, default 8, minimum cycles spent in OPENING or CLOSING before the state may complete.
REQ-002 Parameter: TIMEOUT, default 16, cycle limit in OPENING or CLOSING before the channel declares a fault; TIMEOUT > SETTLE.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 R1  input  2  zone-1 command: 00 stop, 01 low, 10 medium, 11 full water.
REQ-006 R2  input  2  zone-2 command, same encoding as R1.
REQ-007 E  input  2  controller error code: 11 error, 00 no error; any other value is treated as 00.
REQ-008 fb1  input  1  zone-1 valve limit switch: 1 means the valve is physically open.
REQ-009 fb2  input  1  zone-2 valve limit switch, same meaning as fb1.
REQ-010 clr_fault  input  1  single-cycle pulse that clears a sticky channel fault.
REQ-011 V1  output  1  zone-1 valve drive.
REQ-012 V2  output  1  zone-2 valve drive.
REQ-013 ST1  output  2  zone-1 status: 00 closed, 01 transitioning, 10 open, 11 fault.
REQ-014 ST2  output  2  zone-2 status, same encoding as ST1.
REQ-015 F  output  1  OR of both channel faults.

Function
REQ-016 Two identical, independent channel FSMs, each with states CLOSED, OPENING, OPEN, CLOSING and FAULT; all inputs are sampled on the rising edge.
REQ-017 Each channel has a level register (2 bits) and a cycle counter wide enough to hold TIMEOUT; the counter is cleared on every state entry and increments each cycle until it saturates.
REQ-018 A shared free-running 2-bit phase counter increments every cycle and wraps from 3 to 0.
REQ-019 CLOSED: drive 0.
- Cmd != 00 and E != 11 -> OPENING; level <= cmd.
- Otherwise stay in CLOSED.
REQ-020 OPENING: drive 1 to break the valve seal.
- fb = 1 and counter >= SETTLE-1 -> OPEN.
- Else counter == TIMEOUT-1 -> FAULT.
REQ-021 OPEN: drive = (phase < duty), with duty 1 for level 01, 2 for level 10, 4 for level 11.
REQ-022 OPEN, command handling:
- Cmd == 00 -> CLOSING.
- Nonzero cmd != level -> level <= cmd on the same edge; the state stays OPEN.
REQ-023 OPEN with fb = 0 -> FAULT (valve dropped out).
REQ-024 CLOSING: drive 0.
- fb = 0 and counter >= SETTLE-1 -> CLOSED.
- Else counter == TIMEOUT-1 -> FAULT.
REQ-025 CLOSING ignores nonzero commands; reopening happens only from CLOSED.
REQ-026 FAULT: drive 0; the fault is sticky.
- Clr_fault = 1 and cmd == 00 -> CLOSED.
- Clr_fault while cmd != 00 is ignored.
REQ-027 E == 11 forces OPENING or OPEN to CLOSING on the next edge and blocks CLOSED -> OPENING; FAULT and CLOSING are unaffected.
REQ-028 Priority in one cycle: reset > fault condition (timeout / fb drop) > E == 11 > command.
REQ-029 ST mapping: CLOSED 00, OPENING and CLOSING 01, OPEN 10, FAULT 11; F = (ST1 == 11) | (ST2 == 11).
REQ-030 V, ST and F are driven from registered state and registered level; there is no combinational path from any input to any output.
REQ-031 Output latency: the first V change appears one cycle after the input change is sampled.

Reset
REQ-032 Reset mid-operation, including during OPENING, CLOSING or FAULT, returns both channels to CLOSED, with level 00, counters 0 and phase 0.
REQ-033 While reset is asserted, outputs are V1 = V2 = 0, ST1 = ST2 = 00 and F = 0.
REQ-034 Commands sampled on the first edge after reset deassertion are acted on normally.

Verification
REQ-035 R1 = 10, fb1 rises at cycle 3 -> ST1 = 01 with V1 = 1 for 8 cycles, then ST1 = 10 with V1 high 2 of every 4 cycles; R1 = 00 -> CLOSING, then CLOSED 8 cycles after fb1 falls.
REQ-036 R2 = 01 with fb2 held 0 -> ST2 = 01 for 16 cycles, then ST2 = 11, F = 1, V2 = 0; clr_fault while R2 = 01 leaves ST2 = 11; clr_fault with R2 = 00 -> ST2 = 00.
REQ-037 Both zones OPEN at level 11, then E = 11 -> both channels in CLOSING next cycle with V1 = V2 = 0; R1 = 01 while E = 11 and CLOSED -> ST1 stays 00.
REQ-038 Zone 1 OPEN at level 01, R1 changes to 11 -> ST1 stays 10 and V1 = 1 continuously from the next cycle.
REQ-039 fb1 dropped to 0 while OPEN, with E = 11 in the same cycle -> ST1 = 11 (fault wins).
REQ-040 Reset pulsed at OPENING cycle 5 -> ST1 = 00, V1 = 0 during reset; R1 = 10 held -> OPENING restarts with its counter at 0.
